// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA blocks: default operand width and exponentiator states.
package rsa_pkg;

  localparam int unsigned DefaultW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSqr,
    StMul,
    StDone
  } rsa_state_e;

endpackage

// File: rtl/rsa_modexp_if.sv
// Start/finish handshake and operand bus of the modular exponentiator.
interface rsa_modexp_if #(
  parameter int unsigned W = rsa_pkg::DefaultW
) ();

  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exp;
  logic [W-1:0] n;
  logic [W-1:0] result;
  logic         finish;
  logic         busy;
  logic         err;

  modport master (
    output start, base, exp, n,
    input  result, finish, busy, err
  );

  modport slave (
    input  start, base, exp, n,
    output result, finish, busy, err
  );

endinterface

// File: rtl/rsa_modmul.sv
// Sequential a*b mod n by interleaved shift-add, MSB of b first; one bit per cycle.
module rsa_modmul #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] n_i,
  output logic         done_o,
  output logic [W-1:0] res_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0]    a_q, b_q, n_q, acc_q;
  logic [CntW-1:0] cnt_q;

  logic [W+1:0] nx, sum, red1;

  // 2*acc + a < 3n fits in W+2 bits, so two conditional subtractions suffice.
  always_comb begin
    nx   = {2'b00, n_q};
    sum  = ({2'b00, acc_q} << 1) + (b_q[W-1] ? {2'b00, a_q} : '0);
    red1 = (sum >= nx) ? sum - nx : sum;
    res_o = (red1 >= nx) ? W'(red1 - nx) : W'(red1);
  end

  // done_o marks the last iteration cycle; res_o then carries the final product.
  assign done_o = (cnt_q == CntW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      n_q   <= n_i;
      acc_q <= '0;
      cnt_q <= CntW'(W);
    end else if (cnt_q != '0) begin
      acc_q <= res_o;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply base^exp mod n; latency deliberately tracks hw(exp).
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input logic         clk,
  input logic         rst,
  rsa_modexp_if.slave bus
);

  localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;

  rsa_state_e    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  base_q, base_d, exp_q, exp_d, n_q, n_d;
  logic [W-1:0]  result_q, result_d;
  logic          launch_q, launch_d;
  logic          err_pend_q, err_pend_d;
  logic          finish_q, finish_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          accept;
  logic          mm_start, mm_done;
  logic [W-1:0]  mm_a, mm_b, mm_res;

  // The finish cycle still has busy high, so the first new start lands one cycle later.
  assign accept = (state_q == StIdle) && bus.start && !busy_q;

  rsa_modmul #(
    .W(W)
  ) u_modmul (
    .clk    (clk),
    .rst    (rst),
    .start_i(mm_start),
    .a_i    (mm_a),
    .b_i    (mm_b),
    .n_i    (n_q),
    .done_o (mm_done),
    .res_o  (mm_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      acc_q      <= '0;
      base_q     <= '0;
      exp_q      <= '0;
      n_q        <= '0;
      result_q   <= '0;
      launch_q   <= 1'b0;
      err_pend_q <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      n_q        <= n_d;
      result_q   <= result_d;
      launch_q   <= launch_d;
      err_pend_q <= err_pend_d;
      finish_q   <= finish_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    base_d     = base_q;
    exp_d      = exp_q;
    n_d        = n_q;
    launch_d   = 1'b0;
    err_pend_d = err_pend_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          base_d     = bus.base;
          exp_d      = bus.exp;
          n_d        = bus.n;
          err_pend_d = 1'b0;
          if (bus.n < W'(2)) begin
            acc_d   = '0;
            state_d = StDone;
          end else if (bus.base >= bus.n) begin
            acc_d      = '0;
            err_pend_d = 1'b1;
            state_d    = StDone;
          end else begin
            acc_d    = W'(1);
            idx_d    = IdxW'(W - 1);
            launch_d = 1'b1;
            state_d  = StSqr;
          end
        end
      end
      StSqr: begin
        if (mm_done) begin
          acc_d = mm_res;
          if (exp_q[idx_q]) begin
            launch_d = 1'b1;
            state_d  = StMul;
          end else if (idx_q == '0) begin
            state_d = StDone;
          end else begin
            idx_d    = idx_q - IdxW'(1);
            launch_d = 1'b1;
          end
        end
      end
      StMul: begin
        if (mm_done) begin
          acc_d = mm_res;
          if (idx_q == '0) begin
            state_d = StDone;
          end else begin
            idx_d    = idx_q - IdxW'(1);
            launch_d = 1'b1;
            state_d  = StSqr;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mm_start = launch_q;
    mm_a     = acc_q;
    mm_b     = (state_q == StMul) ? base_q : acc_q;
    finish_d = (state_q == StDone);
    result_d = (state_q == StDone) ? acc_q : result_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (state_q == StDone) begin
      err_d = err_pend_q;
    end else begin
      err_d = err_q;
    end
    if (accept) begin
      busy_d = 1'b1;
    end else if (finish_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  assign bus.result = result_q;
  assign bus.finish = finish_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Randomized self-checking bench for rsa_modexp against a plain-arithmetic reference.
module tb_rsa_modexp;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rsa_modexp_if #(.W(W)) bus ();

  rsa_modexp #(
    .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: repeated multiplication, independent of any bit ordering.
  function automatic int ref_modexp(input int b, input int e, input int m);
    int r = 1 % m;
    for (int k = 0; k < e; k++) r = (r * b) % m;
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [7:0] b, input logic [7:0] e,
                        input logic [7:0] m, input bit poke);
    int   exp_res, exp_err, exp_lat, edge_n, extra;
    bit   seen;
    if (m < 2) begin
      exp_res = 0; exp_err = 0; exp_lat = 1;
    end else if (b >= m) begin
      exp_res = 0; exp_err = 1; exp_lat = 1;
    end else begin
      exp_res = ref_modexp(int'(b), int'(e), int'(m));
      exp_err = 0;
      exp_lat = 1 + (W + 1) * (W + $countones(e));
    end
    @(negedge clk);
    bus.start = 1'b1; bus.base = b; bus.exp = e; bus.n = m;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
    edge_n = 0;
    seen   = 1'b0;
    while (!seen && edge_n < 400) begin
      @(negedge clk);
      if (poke && edge_n == 9) begin
        bus.start = 1'b1; bus.base = 8'd1; bus.exp = 8'hff; bus.n = 8'd200;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      edge_n++;
      if (bus.finish) seen = 1'b1;
    end
    bus.start = 1'b0;
    check_val({tag, "_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_lat"}, 32'(edge_n), 32'(exp_lat));
    check_val({tag, "_res"}, 32'(bus.result), 32'(exp_res));
    check_val({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    check_val({tag, "_busy_fin"}, 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    check_val({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.finish) extra++;
    end
    check_val({tag, "_one_fin"}, 32'(extra), 32'd0);
    check_val({tag, "_held"}, 32'(bus.result), 32'(exp_res));
  endtask

  task automatic reset_mid_op();
    int fins;
    @(negedge clk);
    bus.start = 1'b1; bus.base = 8'd2; bus.exp = 8'hff; bus.n = 8'd255;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check_val("rst_mid_result", 32'(bus.result), 32'd0);
    check_val("rst_mid_finish", 32'(bus.finish), 32'd0);
    check_val("rst_mid_busy", 32'(bus.busy), 32'd0);
    check_val("rst_mid_err", 32'(bus.err), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fins = 0;
    for (int k = 0; k < 160; k++) begin
      @(posedge clk);
      #1;
      if (bus.finish || bus.busy) fins++;
    end
    check_val("rst_mid_no_fin", 32'(fins), 32'd0);
  endtask

  initial begin
    logic [7:0] rb, re, rm;
    bus.start = 1'b0; bus.base = '0; bus.exp = '0; bus.n = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_result", 32'(bus.result), 32'd0);
    check_val("rst_finish", 32'(bus.finish), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic", 8'd2, 8'd3, 8'd15, 1'b0);
    run_op("enc", 8'd7, 8'd3, 8'd15, 1'b0);
    run_op("dec", 8'd13, 8'd3, 8'd15, 1'b0);
    run_op("exp00", 8'd2, 8'h00, 8'd255, 1'b0);
    run_op("expff", 8'd2, 8'hff, 8'd255, 1'b0);
    run_op("n1", 8'd0, 8'd5, 8'd1, 1'b0);
    run_op("base_ge_n", 8'd20, 8'd3, 8'd15, 1'b0);
    run_op("err_clear", 8'd3, 8'd4, 8'd7, 1'b0);
    run_op("busy_poke", 8'd2, 8'd3, 8'd15, 1'b1);
    reset_mid_op();
    run_op("after_rst", 8'd5, 8'd7, 8'd33, 1'b0);

    for (int t = 0; t < 24; t++) begin
      rm = 8'($urandom_range(2, 255));
      re = 8'($urandom);
      rb = 8'($urandom % rm);
      if (t % 8 == 7) rb = 8'($urandom_range(int'(rm), 255));
      run_op($sformatf("rnd%0d", t), rb, re, rm, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_modexp.md
# rsa_modexp

Left-to-right square-and-multiply modular exponentiator computing `result = base^exp mod n` on W-bit operands. It consumes the key material produced by the key generator: it encrypts with the public exponent `e` and decrypts with the private exponent `d`. It uses the same start/finish handshake as the key generator. Latency depends on the Hamming weight of `exp` by design, because this block is the timing-side-channel target for the attack benches.

## Interface
- `W`, default 8: operand width in bits (`base`, `exp`, `n`, `result`).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; operands are sampled on the same edge.
- `base`  in  W  message or ciphertext; must satisfy `base < n`.
- `exp`  in  W  exponent (`e` or `d`).
- `n`  in  W  modulus.
- `result`  out  W  `base^exp mod n`; held until the next accepted start.
- `finish`  out  1  one-cycle pulse; `result` and `err` are valid in that cycle.
- `busy`  out  1  high from the accepting edge until `finish` is high.
- `err`  out  1  operand error flag; held until the next accepted start.

## Operation
- Reset values: `result` = 0, `finish` = 0, `busy` = 0, `err` = 0; state = IDLE.
- States: IDLE, SQR, MUL, DONE.
- IDLE: `start` high latches `base`, `exp`, `n` and clears `err`. Outcome by operand check:
  - `n < 2`: `result` = 0, `err` = 0, go to DONE.
  - `base >= n`: `result` = 0, `err` = 1, go to DONE.
  - Otherwise: accumulator = 1, bit index i = W-1, go to SQR.
- SQR: accumulator = accumulator² mod n. If `exp[i]` = 1, go to MUL. Else, if i = 0 go to DONE, otherwise decrement i and stay in SQR.
- MUL: accumulator = accumulator·base mod n. If i = 0 go to DONE, otherwise decrement i and go to SQR.
- DONE: copy accumulator to `result` (non-error path only), pulse `finish` for one cycle, deassert `busy`, return to IDLE.
- Leading zero bits of `exp` are not skipped. Every exponent always costs W squarings.
- `start` while `busy` is high is ignored: no re-latch, no effect on the current operation.
- `start` in the DONE cycle is also ignored. A new request is accepted in the first IDLE cycle after `finish`.
- `exp` = 0 gives `result` = 1 (for `n >= 2`).
- Asynchronous `rst` mid-operation: all outputs go to their reset values immediately, the in-flight operation is discarded, and no `finish` is issued.

## Timing
- Every modular multiply takes exactly W+1 cycles: 1 launch cycle plus W iteration cycles.
- Normal path: `finish` is high L = 1 + (W+1)·(W + hw(exp)) rising edges after the edge that sampled `start`.
  - W = 8: L = 73 + 9·hw(exp).
  - L ranges from 73 (`exp` = 0) to 145 (`exp` = 0xFF).
- Early-exit paths (`n < 2`, `base >= n`): `finish` is high 1 edge after the sampling edge.
- `result` updates on the same edge that raises `finish`.
- `busy` is low from the edge where `finish` falls.

## Structure
- Shared package `rsa_pkg` holds the parameter `W` default and the state enumeration (IDLE/SQR/MUL/DONE) used by this block and the key generator bench.
- Sub-module `rsa_modmul` computes `a·b mod n` by interleaved shift-add, MSB of `b` first:
  - Each step: acc = 2·acc + (b bit ? a : 0), then subtract n up to twice.
  - Intermediate width is W+2 bits. Preconditions: acc, a < n.
  - Ports: start pulse, `done` pulse after W iteration cycles.
  - Used sequentially for both squaring and multiplying; it is not instantiated twice.

## Test plan
- Reset, then `base` = 2, `exp` = 3, `n` = 15 -> `result` = 8, `finish` at edge 91, `err` = 0.
- Round trip with key-generator output (p = 3, q = 5, e = 3, d = 3):
  - Encrypt `base` = 7, `exp` = 3, `n` = 15 -> `result` = 13.
  - Decrypt `base` = 13, `exp` = 3, `n` = 15 -> `result` = 7.
  - Both finish at edge 91.
- Latency extremes, `n` = 255, `base` = 2:
  - `exp` = 0x00 -> `result` = 1 at edge 73.
  - `exp` = 0xFF -> `result` = 128 at edge 145.
- Boundary and error cases:
  - `n` = 1 -> `result` = 0, `err` = 0, `finish` at edge 1.
  - `base` = 20, `n` = 15 -> `result` = 0, `err` = 1, `finish` at edge 1.
- Busy protection: second `start` with different operands 10 cycles into the `exp` = 3 operation -> ignored; `result` = 8 at edge 91 and exactly one `finish`.
- Reset mid-operation: assert `rst` at edge 40 of an `exp` = 0xFF run -> all outputs 0 immediately and no `finish`. A new start after release completes normally.
